gray_world_awb: RTL

- Parametrised, self-contained gray-world auto white balance for an AXI4-Stream video path with NCH channels of PIX_W bits.
- Accumulates per-channel sums over each frame, then computes per-channel gains with one shared sequential divider.
- Gains are applied from the next frame onward.
- Supports backpressure (tready), bypass mode, output saturation and overrun reporting.
- Sits between the video input stage and the colour-correction / Kelvin stage.

---
 rtl/gray_world_pkg.sv | 31 +++
 rtl/seq_div_uu.sv | 69 ++++++
 rtl/gray_world_awb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_world_pkg.sv
// Shared types and helpers for the gray-world auto white balance block.
//   awb_state_t : gain computation FSM states
//   unity_gain  : 1.0 expressed with a given number of fractional bits
//   saturate    : clamp an unsigned value to the largest w-bit value
//   chan_lsb    : LSB position of channel c in a packed bus (channel 0 in the MSBs)
package gray_world_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUMALL,
        ST_DIV,
        ST_NEXT,
        ST_READY
    } awb_state_t;

    function automatic longint unsigned unity_gain(input int unsigned frac);
        return 64'd1 << frac;
    endfunction

    function automatic longint unsigned saturate(input longint unsigned v, input int unsigned w);
        longint unsigned lim;
        lim = (64'd1 << w) - 64'd1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic int unsigned chan_lsb(input int unsigned c, input int unsigned nch,
                                             input int unsigned w);
        return (nch - 1 - c) * w;
    endfunction

endpackage

// File: rtl/seq_div_uu.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a division (ignored while busy)
//   dividend     : DVD_W-bit dividend, sampled on start
//   divisor      : DVS_W-bit divisor, sampled on start
//   busy         : division in progress
//   done         : one-cycle pulse, quotient valid from this cycle until the next start
//   quotient     : DVD_W-bit result
//   div_by_zero  : divisor was zero for the current result
module seq_div_uu #(
    parameter int unsigned DVD_W = 40,
    parameter int unsigned DVS_W = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic             div_by_zero
);
    localparam int unsigned CNT_W = $clog2(DVD_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [DVS_W:0]   shifted;
    logic             fits;

    // The dividend is shifted out of the quotient register MSB-first while
    // quotient bits are shifted in at the bottom.
    always_comb begin
        shifted = {rem, quotient[DVD_W-1]};
        fits    = shifted >= {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            dvs         <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy        <= 1'b1;
                cnt         <= CNT_W'(DVD_W);
                rem         <= '0;
                dvs         <= divisor;
                quotient    <= dividend;
                div_by_zero <= (divisor == '0);
            end else if (busy) begin
                rem      <= fits ? DVS_W'(shifted - {1'b0, dvs}) : shifted[DVS_W-1:0];
                quotient <= {quotient[DVD_W-2:0], fits};
                cnt      <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gray_world_awb.sv
// Gray-world auto white balance on an AXI4-Stream video path.
// Per-channel frame sums are gathered on accepted beats; at end of frame the
// gains S/(NCH*sum_c) are computed with one shared divider and committed at
// the next start of frame. Pixels pass through a 2-stage pipeline that
// multiplies each channel by its gain with rounding and saturation.
//   clk, rst        : clock, synchronous active-high reset
//   s_axis_*        : input stream (tuser = start of frame, tlast = end of line)
//   m_axis_*        : corrected output stream, latency 2 accepted beats
//   en              : 1 = apply gains, 0 = unity gain (statistics still gathered)
//   gains_o         : active gains, channel 0 in the MSBs
//   frame_done      : pulse when a new gain set is committed
//   stat_overrun    : pulse when a frame's statistics are dropped
module gray_world_awb
    import gray_world_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned NCH       = 3,
    parameter int unsigned NLINE     = 349,
    parameter int unsigned NSCREEN   = 349,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned GAIN_FRAC = 8,
    parameter int unsigned GAIN_W    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic [NCH*PIX_W-1:0]    s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic [NCH*PIX_W-1:0]    m_axis_tdata,
    input  logic                    en,
    output logic [NCH*GAIN_W-1:0]   gains_o,
    output logic                    frame_done,
    output logic                    stat_overrun
);
    localparam int unsigned DVD_W = ACC_W + GAIN_FRAC;
    localparam int unsigned DVS_W = ACC_W + ((NCH > 1) ? $clog2(NCH) : 1);
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LN_W  = (NSCREEN > 1) ? $clog2(NSCREEN) : 1;
    localparam int unsigned PW    = PIX_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [PW-1:0]     ROUND = PW'(unity_gain(GAIN_FRAC - 1));

    if (NLINE == 0 || NSCREEN == 0 || GAIN_FRAC == 0 || GAIN_FRAC >= GAIN_W) begin : g_bad_params
        $error("gray_world_awb: invalid parameter set");
    end

    // ---------------- statistics ----------------
    logic             beat, eof;
    logic [LN_W-1:0]  line_cnt, line_base;
    logic [ACC_W-1:0] acc [NCH];
    logic [ACC_W-1:0] acc_add [NCH];
    logic [ACC_W-1:0] sums [NCH];
    logic [ACC_W-1:0] sum_all, total;

    awb_state_t       state, state_nx;
    logic [CH_W-1:0]  ch;
    logic [GAIN_W-1:0] pending [NCH];
    logic [GAIN_W-1:0] gains [NCH];
    logic [GAIN_W-1:0] q_clip;

    logic             div_start, div_busy, div_done, div_dz;
    logic [DVD_W-1:0] div_quo;
    logic [DVS_W-1:0] div_divisor;

    assign beat = s_axis_tvalid & s_axis_tready;

    // tuser restarts the line count before tlast is evaluated on the same beat.
    always_comb begin
        line_base = s_axis_tuser ? '0 : line_cnt;
        eof       = beat & s_axis_tlast & (line_base == LN_W'(NSCREEN - 1));
        for (int unsigned i = 0; i < NCH; i++) begin
            acc_add[i] = (s_axis_tuser ? '0 : acc[i])
                       + ACC_W'(s_axis_tdata[chan_lsb(i, NCH, PIX_W) +: PIX_W]);
        end
        sum_all = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sum_all = sum_all + sums[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt     <= '0;
            stat_overrun <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                sums[i] <= '0;
            end
        end else begin
            stat_overrun <= eof & (state != ST_IDLE);
            if (beat) begin
                if (s_axis_tlast) begin
                    line_cnt <= (line_base == LN_W'(NSCREEN - 1)) ? '0 : line_base + 1'b1;
                end else begin
                    line_cnt <= line_base;
                end
                for (int unsigned i = 0; i < NCH; i++) begin
                    acc[i] <= eof ? '0 : acc_add[i];
                    if (eof && state == ST_IDLE) begin
                        sums[i] <= acc_add[i];
                    end
                end
            end
        end
    end

    // ---------------- gain FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        unique case (state)
            ST_IDLE:   if (eof) state_nx = ST_SUMALL;
            ST_SUMALL: state_nx = ST_DIV;
            ST_DIV: begin
                // Kick the divider once on entry; the done cycle moves on.
                div_start = ~div_busy & ~div_done;
                if (div_done) state_nx = ST_NEXT;
            end
            ST_NEXT:   state_nx = (ch == CH_W'(NCH - 1)) ? ST_READY : ST_DIV;
            ST_READY:  if (beat && s_axis_tuser) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    assign div_divisor = DVS_W'(sums[ch]) * DVS_W'(NCH);
    assign q_clip      = div_dz ? '1 : GAIN_W'(saturate(64'(div_quo), GAIN_W));

    seq_div_uu #(
        .DVD_W(DVD_W),
        .DVS_W(DVS_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .dividend    ({total, {GAIN_FRAC{1'b0}}}),
        .divisor     (div_divisor),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quo),
        .div_by_zero (div_dz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            total      <= '0;
            ch         <= '0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                pending[i] <= UNITY;
                gains[i]   <= UNITY;
            end
        end else begin
            frame_done <= 1'b0;
            if (state == ST_SUMALL) begin
                total <= sum_all;
                ch    <= '0;
            end
            if (state == ST_NEXT) begin
                pending[ch] <= q_clip;
                if (ch != CH_W'(NCH - 1)) ch <= ch + 1'b1;
            end
            // Commit only on an accepted start of frame, so gains never change mid-frame.
            if (state == ST_READY && beat && s_axis_tuser) begin
                frame_done <= 1'b1;
                for (int unsigned i = 0; i < NCH; i++) begin
                    gains[i] <= pending[i];
                end
            end
        end
    end

    always_comb begin
        gains_o = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            gains_o[chan_lsb(i, NCH, GAIN_W) +: GAIN_W] = gains[i];
        end
    end

    // ---------------- 2-stage datapath ----------------
    logic                 s1_valid, s1_user, s1_last, s1_en;
    logic [NCH*PIX_W-1:0] s1_data, s2_data;
    logic                 s2_adv;

    assign s2_adv        = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = ~rst & (~s1_valid | s2_adv);

    always_comb begin
        s2_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            logic [GAIN_W-1:0] g;
            logic [PW-1:0]     prod;
            g    = s1_en ? gains[i] : UNITY;
            prod = PW'(s1_data[chan_lsb(i, NCH, PIX_W) +: PIX_W]) * PW'(g) + ROUND;
            s2_data[chan_lsb(i, NCH, PIX_W) +: PIX_W] =
                PIX_W'(saturate(64'(prod >> GAIN_FRAC), PIX_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_user       <= 1'b0;
            s1_last       <= 1'b0;
            s1_en         <= 1'b0;
            s1_data       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (s_axis_tready) begin
                s1_valid <= s_axis_tvalid;
                if (s_axis_tvalid) begin
                    s1_user <= s_axis_tuser;
                    s1_last <= s_axis_tlast;
                    s1_en   <= en;
                    s1_data <= s_axis_tdata;
                end
            end
            if (s2_adv) begin
                m_axis_tvalid <= s1_valid;
                if (s1_valid) begin
                    m_axis_tuser <= s1_user;
                    m_axis_tlast <= s1_last;
                    m_axis_tdata <= s2_data;
                end
            end
        end
    end

endmodule
